// File: rtl/timer_counter_sequencer_pkg.sv
// Shared definitions for the timer/counter sequencer: FSM state encoding and
// default widths for the prescale timer and the controlled counter.
package timer_counter_sequencer_pkg;

  localparam int TIMER_W_DEF = 4;
  localparam int COUNT_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter_sequencer_prescale_timer.sv
// Prescale timer: counts 0..period while enabled and emits a one-cycle tick
// on the cycle it wraps. clr forces it back to zero.
module prescale_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic [W-1:0] timer,
  output logic         tick
);

  assign tick = en && (timer == period);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset)      timer <= '0;
    else if (clr)    timer <= '0;
    else if (tick)   timer <= '0;
    else if (en)     timer <= timer + 1'b1;
  end

endmodule

// File: rtl/timer_counter_sequencer.sv
// Sequencer for the prescale-timer / controlled-counter pair: start/stop/pause
// control, shadowed run configuration and completion flag.
// Build option: define AUTO_RELOAD_EN for continuous reload instead of single-shot.
module timer_counter_sequencer
  import timer_counter_sequencer_pkg::*;
#(
  parameter int TIMER_W = TIMER_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [TIMER_W-1:0] prescale,
  input  logic [COUNT_W-1:0] limit,
  output logic [TIMER_W-1:0] timer,
  output logic [COUNT_W-1:0] control_counter,
  output logic               busy,
  output logic               done
);

  state_e             state, state_nxt;
  logic [TIMER_W-1:0] shadow_p;
  logic [COUNT_W-1:0] shadow_l;
  logic               active, load, abort, run_go, tick, terminal;

  assign active   = (state == RUN) || (state == PAUSE);
  assign load     = (state == IDLE) && start;
  assign abort    = active && stop;
  // Leaving PAUSE advances on the same edge, so frozen cycles equal pause-high cycles.
  assign run_go   = active && !stop && !pause;
  assign terminal = tick && (control_counter == shadow_l);
  assign busy     = active;

  prescale_timer #(.W(TIMER_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (run_go),
    .clr    (load || abort),
    .period (shadow_p),
    .timer  (timer),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = RUN;
      RUN, PAUSE: begin
        if (stop)          state_nxt = IDLE;
        else if (pause)    state_nxt = PAUSE;
        else if (terminal) begin
`ifdef AUTO_RELOAD_EN
          state_nxt = RUN;
`else
          state_nxt = DONE;
`endif
        end else           state_nxt = RUN;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_p        <= '0;
      shadow_l        <= '0;
      control_counter <= '0;
      done            <= 1'b0;
    end else begin
      done <= terminal;
      if (load) begin
        shadow_p        <= prescale;
        shadow_l        <= limit;
        control_counter <= '0;
      end else if (abort) begin
        control_counter <= '0;
      end else if (tick) begin
        if (!terminal) control_counter <= control_counter + 1'b1;
`ifdef AUTO_RELOAD_EN
        else           control_counter <= '0;
`endif
      end
    end
  end

endmodule
